// File: rtl/imem_loader.sv
// imem_loader: boot loader that assembles a byte stream into 19-bit words and writes instruction memory.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int WORD_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int         CW      = ADDR_W + 1;
    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [3:0] {
        S_IDLE, S_COUNT, S_B0, S_B1, S_B2, S_WR, S_CHK, S_DONE, S_ERR
    } state_t;
`else
    typedef enum logic [3:0] {
        S_IDLE, S_COUNT, S_B0, S_B1, S_B2, S_WR, S_DONE, S_ERR
    } state_t;
`endif

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_n;
    logic [CW-1:0]     r_words;
    logic [7:0]        r_b0;
    logic [7:0]        r_b1;
    logic [ADDR_W-1:0] r_waddr;
    logic [WORD_W-1:0] r_wdata;
    logic              w_xfer;
    logic              w_start;
    logic              w_last;
    logic              w_b2_ok;
    logic [CW-1:0]     w_words_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    assign in_ready = (r_state == S_COUNT) || (r_state == S_B0) || (r_state == S_B1) ||
`ifdef IMEM_LOADER_CHECKSUM_EN
                      (r_state == S_CHK) ||
`endif
                      (r_state == S_B2);

    assign w_xfer      = in_valid && in_ready;
    assign w_start     = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
    assign w_words_inc = r_words + CW'(1);
    assign w_last      = (w_words_inc == r_n);
    assign w_b2_ok     = (in_data[7:3] == 5'd0);

    // A write pending in WR is dropped on the very cycle reset is raised.
    assign imem_we      = (r_state == S_WR) && !reset;
    assign imem_waddr   = r_waddr;
    assign imem_wdata   = r_wdata;
    assign cpu_hold     = (r_state != S_DONE);
    assign done         = (r_state == S_DONE);
    assign error        = (r_state == S_ERR);
    assign words_loaded = r_words;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_COUNT;
            S_COUNT: if (w_xfer) w_next = ((in_data == 8'd0) || (in_data > DEPTH_B)) ? S_ERR : S_B0;
            S_B0:    if (w_xfer) w_next = S_B1;
            S_B1:    if (w_xfer) w_next = S_B2;
            S_B2:    if (w_xfer) w_next = w_b2_ok ? S_WR : S_ERR;
            S_WR: begin
                if (w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_next = S_CHK;
`else
                    w_next = S_DONE;
`endif
                end else begin
                    w_next = S_B0;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:   if (w_xfer) w_next = (in_data == r_csum) ? S_DONE : S_ERR;
`endif
            S_DONE:  if (start) w_next = S_COUNT;
            S_ERR:   if (start) w_next = S_COUNT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_words <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum  <= '0;
`endif
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_words <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_csum  <= '0;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (w_xfer) r_csum <= r_csum ^ in_data;
`endif
            if (w_xfer && (r_state == S_COUNT)) r_n <= CW'(in_data);
            if (w_xfer && (r_state == S_B2) && w_b2_ok) begin
                r_waddr <= r_words[ADDR_W-1:0];
                r_wdata <= WORD_W'({in_data[2:0], r_b1, r_b0});
            end
            if (r_state == S_WR) r_words <= w_words_inc;
        end
    end

    // Byte staging for word assembly; contents are don't-care outside a load.
    always_ff @(posedge clk) begin
        if (w_xfer && (r_state == S_B0)) r_b0 <= in_data;
        if (w_xfer && (r_state == S_B1)) r_b1 <= in_data;
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for the instruction-memory boot loader.
module tb_imem_loader;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int WORD_W = 19;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [WORD_W-1:0] imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
    );

    int          n_chk = 0;
    int          n_err = 0;
    bit          stall = 1'b0;
    logic [7:0]  ck;
    logic [18:0] img [DEPTH];
    int          wlog_a [$];
    int          wlog_d [$];
`ifdef IMEM_LOADER_CHECKSUM_EN
    bit          ck_flip = 1'b0;
`endif

    // Memory-side write log.
    always @(posedge clk) begin
        if (imem_we) begin
            wlog_a.push_back(int'(imem_waddr));
            wlog_d.push_back(int'(imem_wdata));
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
        else ck ^= b;
        @(negedge clk);
        in_valid = 1'b0;
        if (stall) @(negedge clk);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        ck    = 8'h00;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input int i);
        send_byte(img[i][7:0]);
        send_byte(img[i][15:8]);
        send_byte({5'd0, img[i][18:16]});
    endtask

    task automatic send_image(input int n);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) send_word(i);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(ck_flip ? (ck ^ 8'h01) : ck);
`endif
    endtask

    task automatic wait_end;
        int t;
        t = 0;
        while (!done && !error && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("end_seen", 32'(done | error), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_we"}, 32'(imem_we), 32'd0);
        check({tag, "_waddr"}, 32'(imem_waddr), 32'd0);
        check({tag, "_wdata"}, 32'(imem_wdata), 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int bad;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; ck = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);

        // Basic two-word load
        img[0] = 19'h51234;
        img[1] = 19'h7FFFF;
        base = wlog_a.size();
        pulse_start;
        send_image(2);
        wait_end;
        check("basic_nwr", 32'(wlog_a.size() - base), 32'd2);
        if (wlog_a.size() - base == 2) begin
            check("basic_a0", 32'(wlog_a[base]), 32'd0);
            check("basic_d0", 32'(wlog_d[base]), 32'h51234);
            check("basic_a1", 32'(wlog_a[base+1]), 32'd1);
            check("basic_d1", 32'(wlog_d[base+1]), 32'h7FFFF);
        end
        check("basic_words", 32'(words_loaded), 32'd2);
        check("basic_done", 32'(done), 32'd1);
        check("basic_error", 32'(error), 32'd0);
        check("basic_hold", 32'(cpu_hold), 32'd0);
        check("basic_ready", 32'(in_ready), 32'd0);

        // Count byte 0 and 33 are rejected
        base = wlog_a.size();
        pulse_start;
        check("restart_hold", 32'(cpu_hold), 32'd1);
        check("restart_words", 32'(words_loaded), 32'd0);
        send_byte(8'h00);
        wait_end;
        check("cnt0_error", 32'(error), 32'd1);
        check("cnt0_hold", 32'(cpu_hold), 32'd1);
        check("cnt0_done", 32'(done), 32'd0);
        pulse_start;
        send_byte(8'h21);
        wait_end;
        check("cnt33_error", 32'(error), 32'd1);
        check("cnt33_hold", 32'(cpu_hold), 32'd1);
        check("cnt_nwr", 32'(wlog_a.size() - base), 32'd0);

        // Nonzero upper bits in B2
        pulse_start;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h08);
        wait_end;
        check("b2_error", 32'(error), 32'd1);
        check("b2_words", 32'(words_loaded), 32'd0);
        check("b2_nwr", 32'(wlog_a.size() - base), 32'd0);

        // Full 32-word image with valid toggling
        for (int i = 0; i < DEPTH; i++) img[i] = 19'((i * 32'h2B4D + 32'h10001) & 32'h7FFFF);
        stall = 1'b1;
        base = wlog_a.size();
        pulse_start;
        send_image(DEPTH);
        wait_end;
        stall = 1'b0;
        check("full_nwr", 32'(wlog_a.size() - base), 32'd32);
        bad = 0;
        if (wlog_a.size() - base == DEPTH) begin
            for (int i = 0; i < DEPTH; i++)
                if (wlog_a[base+i] != i || wlog_d[base+i] != int'(img[i])) bad++;
        end else begin
            bad = -1;
        end
        check("full_order", 32'(bad), 32'd0);
        check("full_words", 32'(words_loaded), 32'd32);
        check("full_done", 32'(done), 32'd1);

        // Reset during B1 of word 5
        base = wlog_a.size();
        pulse_start;
        send_byte(8'h08);
        for (int i = 0; i < 5; i++) send_word(i);
        send_byte(img[5][7:0]);
        check("mid_words", 32'(words_loaded), 32'd5);
        reset = 1'b1;
        in_data = img[5][15:8];
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_reset_vals("midrst");
        reset = 1'b0;
        @(negedge clk);
        check("mid_nwr", 32'(wlog_a.size() - base), 32'd5);

        // Reload after reset
        img[0] = 19'h51234;
        img[1] = 19'h7FFFF;
        base = wlog_a.size();
        pulse_start;
        send_image(2);
        wait_end;
        check("reload_done", 32'(done), 32'd1);
        check("reload_nwr", 32'(wlog_a.size() - base), 32'd2);
        if (wlog_a.size() - base == 2) check("reload_d1", 32'(wlog_d[base+1]), 32'h7FFFF);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Wrong checksum 0x27, then correct 0x26
        base = wlog_a.size();
        ck_flip = 1'b1;
        pulse_start;
        send_image(2);
        ck_flip = 1'b0;
        wait_end;
        check("ck_bad_error", 32'(error), 32'd1);
        check("ck_bad_hold", 32'(cpu_hold), 32'd1);
        check("ck_bad_nwr", 32'(wlog_a.size() - base), 32'd2);
        pulse_start;
        send_image(2);
        wait_end;
        check("ck_good_done", 32'(done), 32'd1);
        check("ck_good_hold", 32'(cpu_hold), 32'd0);
`endif

        // Reset raised while in WR suppresses that write
        pulse_start;
        send_byte(8'h01);
        send_word(0);
        check("wr_pre_we", 32'(imem_we), 32'd1);
        base = wlog_a.size();
        reset = 1'b1;
        #1;
        check("wr_rst_we", 32'(imem_we), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("wr_rst_nwr", 32'(wlog_a.size() - base), 32'd0);
        check("wr_rst_words", 32'(words_loaded), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader: writer side of the CPU instruction-memory fetch path.
- Accepts a byte stream over a valid/ready handshake and assembles 19-bit instruction words.
- Writes each word into the 32-entry instruction memory through a single write port.
- Holds the CPU in reset until a complete, well-formed image has been committed.

Parameters:
- DEPTH, 32, number of instruction words; max legal image length.
- ADDR_W, 5, instruction memory address width; must satisfy 2^ADDR_W = DEPTH.
- WORD_W, 19, instruction width in bits.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load; honoured only in IDLE, DONE or ERR.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction memory write strobe.
- imem_waddr  output  ADDR_W  write address.
- imem_wdata  output  WORD_W  write data.
- cpu_hold  output  1  OR into the CPU reset.
- done  output  1  image loaded OK; level.
- error  output  1  image rejected; level.
- words_loaded  output  ADDR_W+1  count of words written in the current load.

Behaviour:
- Reset values: state=IDLE, in_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, cpu_hold=1, done=0, error=0, words_loaded=0, running checksum=0.
- A byte transfers only on a clock edge where in_valid=1 and in_ready=1.
- in_ready=1 only in states COUNT, B0, B1, B2 and CHK.
- Stream format:
  - Count byte N, legal range 1..DEPTH.
  - Then N words, 3 bytes each, little-endian: B0 gives wdata[7:0], B1 gives [15:8], B2[2:0] gives [18:16].
  - Then, with the optional feature compiled in, one checksum byte.
- State IDLE:
  - start moves to COUNT.
  - Checksum and words_loaded clear on start.
- State COUNT:
  - On transfer, N=0 or N>DEPTH moves to ERR.
  - Otherwise N is latched and state moves to B0.
- States B0 -> B1 -> B2: one transfer each.
  - B2 with in_data[7:3]!=0 moves to ERR; no write occurs for that word.
- State WR (1 cycle):
  - imem_we=1, imem_waddr = words_loaded[ADDR_W-1:0], imem_wdata = assembled word.
  - in_ready=0.
  - words_loaded increments at the end of the cycle.
  - If words_loaded+1 == N, go to CHK (feature on) or DONE (feature off); else go to B0.
- imem_waddr and imem_wdata are registered and stable during WR; imem_we is low in every other state.
- Per-word cost: 4 cycles minimum (3 transfers plus WR). Back-pressure via in_valid=0 stalls in place without limit.
- State DONE: done=1, cpu_hold=0, error=0.
- State ERR:
  - error=1, cpu_hold=1, done=0.
  - Words already written remain in memory.
- start in DONE or ERR:
  - Clears done, error, words_loaded and checksum.
  - Re-asserts cpu_hold the next cycle.
  - Enters COUNT.
- start in any other state is ignored; start and a byte transfer in the same cycle: start is ignored.
- Bytes offered while in_ready=0 are not consumed.
- cpu_hold = 1 in every state except DONE.
- reset during any state aborts the load, returns to reset values and suppresses any pending write: imem_we=0 on the reset cycle.
- words_loaded reaches DEPTH (32) without wrap because its width is ADDR_W+1; an address of 32 is never issued.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - The running checksum is the XOR of the count byte and every data byte, updated on each transfer.
  - After the last WR, state CHK accepts one byte: equal to the running checksum goes to DONE, mismatch goes to ERR.
  - Memory contents are already written either way; only cpu_hold release is gated.
- Undefined:
  - No checksum register and no CHK state; last WR goes directly to DONE.
  - A byte following the image is not consumed.

Test Plan:
- Basic load:
  - Stimulus: start; bytes 02, 34,12,05, FF,FF,07 (plus checksum 02^34^12^05^FF^FF^07=26 if feature on).
  - Response: two writes, addr0=0x51234 and addr1=0x7FFFF; words_loaded=2; done=1; cpu_hold=0 the cycle after DONE entry.
- Bad count:
  - Stimulus: count 00, and separately count 21 (33).
  - Response: ERR, error=1, cpu_hold=1, imem_we never asserted.
- Bad upper bits:
  - Stimulus: count 01, bytes 00,00,08.
  - Response: ERR, no write, words_loaded=0.
- Full image with stalls:
  - Stimulus: N=32 with in_valid toggling every other cycle.
  - Response: addresses 0..31 written in order, each exactly once; words_loaded=32; done=1.
- Reset mid-load:
  - Stimulus: assert reset during B1 of word 5.
  - Response: next cycle all reset values; no write of word 5; a fresh start plus image reloads correctly.
- Checksum (feature on):
  - Stimulus: basic image with checksum byte 27.
  - Response: ERR, cpu_hold=1; a restart with start and the correct 26 gives DONE.
